tt_pin_driver: RTL
==================

Name: tt_pin_driver

Overview:
- On-chip stimulus/response engine for the user-project pin interface: the other end of the pin bus that our cocotb testbench drives from outside.
- Holds a small vector memory and drives ui_in, uio_in, ena and rst_n into a wrapped tt_um_* design.
- Samples uo_out, compares it against masked expectations, and reports pass/fail, error count and first failing index.
- Used for in-silicon self-test and for bench-free regression on the FPGA prototype.

Parameters:
- ADDR_W, 4: vector address width; DEPTH = 2**ADDR_W entries.
- RST_CYCLES, 4: number of cycles dut_rst_n is held low at the start of each run; must be >= 1.
- SETTLE, 2: extra cycles each vector is held before compare; each vector is applied for SETTLE+1 cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  vector memory write strobe
- wr_addr  in  ADDR_W  vector memory write address
- wr_data  in  32  vector word: [31:24] ui_in, [23:16] uio_in, [15:8] exp_uo, [7:0] mask_uo
- num_vec  in  ADDR_W+1  number of vectors to run (0..DEPTH); sampled on start
- start  in  1  one-cycle run request
- busy  out  1  high while a run is in progress
- done  out  1  high after a run completes; held until the next accepted start
- pass  out  1  valid while done=1; high when err_count==0
- err_count  out  8  saturating mismatch count
- first_err_idx  out  ADDR_W  index of the first mismatching vector; valid when err_count!=0
- dut_ui_in  out  8  drives the DUT's ui_in
- dut_uio_in  out  8  drives the DUT's uio_in
- dut_ena  out  1  drives the DUT's ena
- dut_rst_n  out  1  drives the DUT's rst_n
- dut_uo_out  in  8  DUT uo_out
- dut_uio_out  in  8  DUT uio_out (used only with the optional feature)
- dut_uio_oe  in  8  DUT uio_oe (used only with the optional feature)

Behaviour:
- Reset (async, rst_n=0) values:
  - busy=0, done=0, pass=0, err_count=0, first_err_idx=0.
  - dut_ui_in=0, dut_uio_in=0, dut_ena=0, dut_rst_n=0; state=IDLE.
  - Vector memory contents are not reset.
- Vector memory:
  - DEPTH x 32, synchronous write, combinational read.
  - A write takes effect on the clk edge where wr_en=1.
  - Writes are ignored while busy=1.
- States: IDLE -> DRST -> APPLY -> DONE.
- IDLE:
  - On start=1, latch num_vec, clear err_count, first_err_idx, done and pass, and go to DRST.
  - busy rises on the following cycle.
- DRST:
  - dut_ena=1, dut_rst_n=0, dut_ui_in=0, dut_uio_in=0 for exactly RST_CYCLES cycles.
  - If num_vec==0, go to DONE; otherwise go to APPLY with idx=0.
- APPLY:
  - dut_rst_n=1; dut_ui_in and dut_uio_in come from mem[idx] and stay stable for SETTLE+1 cycles.
  - On the edge ending the last of those cycles, compare (dut_uo_out & mask_uo) with (exp_uo & mask_uo).
  - On mismatch, increment err_count, saturating at 255. If this is the first mismatch, load first_err_idx with idx.
  - If idx == num_vec-1, go to DONE; otherwise increment idx and apply the next vector with no gap cycle.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - dut_ena stays 1 and dut_rst_n stays 1; dut pin outputs keep the last vector.
  - The next start restarts the run from DRST.
- Busy length: busy is high for exactly RST_CYCLES + num_vec*(SETTLE+1) cycles.
- start while busy=1 is ignored.
- num_vec > DEPTH is clamped to DEPTH.
- mask_uo=0 means the vector always passes.
- Asserting rst_n mid-run returns everything immediately to the reset values; the DUT sees dut_rst_n=0 asynchronously.

Optional Feature:
- Macro: TT_PIN_UIO_CHECK_EN.
- Defined:
  - The memory word grows to 48 bits; wr_data[47:40] = exp_uio, wr_data[39:32] = mask_uio.
  - At compare, bits where dut_uio_oe=1 and mask_uio=1 must also match dut_uio_out against exp_uio.
  - A failure in either uo or uio counts as a single mismatch for that vector.
  - Port last_fail_uo (8, out, reset 0) holds dut_uo_out captured at the most recent mismatch.
- Undefined:
  - wr_data is 32 bits and last_fail_uo is absent.
  - dut_uio_out and dut_uio_oe are unused.

Test Plan:
- Loopback DUT (uo_out=ui_in). Load 4 vectors with ui_in=0x11,0x22,0x33,0x44, exp_uo equal to ui_in, mask 0xFF. Run num_vec=4 with defaults -> busy high for 16 cycles, done=1, pass=1, err_count=0.
- Same setup with vector 2 exp_uo=0x30 -> err_count=1, first_err_idx=2, pass=0. With the macro defined, last_fail_uo=0x33.
- Same setup with vector 2 exp_uo=0x30 but mask_uo=0xF0 -> pass=1.
- num_vec=0 -> dut_rst_n low for 4 cycles, then done=1, pass=1.
- All 16 vectors mismatching across 20 repeated runs without clearing the DUT: err_count resets on each start. In a separate run, force 300 mismatches via SETTLE=0 and ADDR_W=9 -> err_count saturates at 255.
- Assert rst_n low mid-APPLY -> all outputs return to reset values immediately. A start afterwards completes normally; wr_en pulses issued while busy do not alter the memory.

Source files
------------

// File: rtl/tt_pin_driver.sv
// tt_pin_driver: on-chip stimulus/compare engine driving a wrapped tt_um_* design from a vector memory.
// Define TT_PIN_UIO_CHECK_EN to add masked uio_out checking and last_fail_uo capture.
module tt_pin_driver #(
    parameter int ADDR_W     = 4,
    parameter int RST_CYCLES = 4,
    parameter int SETTLE     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
`ifdef TT_PIN_UIO_CHECK_EN
    input  logic [47:0]       wr_data,
`else
    input  logic [31:0]       wr_data,
`endif
    input  logic [ADDR_W:0]   num_vec,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_idx,
`ifdef TT_PIN_UIO_CHECK_EN
    output logic [7:0]        last_fail_uo,
`endif
    output logic [7:0]        dut_ui_in,
    output logic [7:0]        dut_uio_in,
    output logic              dut_ena,
    output logic              dut_rst_n,
    input  logic [7:0]        dut_uo_out,
    input  logic [7:0]        dut_uio_out,
    input  logic [7:0]        dut_uio_oe
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef TT_PIN_UIO_CHECK_EN
    localparam int WW = 48;
`else
    localparam int WW = 32;
`endif
    localparam int CMAX = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE + 1;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRST, S_APPLY, S_DONE} state_t;

    state_t            r_state;
    logic [WW-1:0]     r_mem [DEPTH];
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W:0]   r_n;

    logic [WW-1:0]     w_cur;
    logic [15:0]       w_nxt_pins;
    logic              w_bad;
    logic              w_uio_bad;
    logic              w_last;
    logic [7:0]        w_err_next;
    logic [ADDR_W:0]   w_n;

    always_ff @(posedge clk)
        if (wr_en && !busy) r_mem[wr_addr] <= wr_data;

    assign w_cur      = r_mem[r_idx];
    assign w_nxt_pins = r_mem[r_idx + 1'b1][31:16];
`ifdef TT_PIN_UIO_CHECK_EN
    assign w_uio_bad  = |((dut_uio_out ^ w_cur[47:40]) & w_cur[39:32] & dut_uio_oe);
`else
    logic w_unused_uio;
    assign w_unused_uio = ^{dut_uio_out, dut_uio_oe};
    assign w_uio_bad    = 1'b0;
`endif
    assign w_bad      = |((dut_uo_out ^ w_cur[15:8]) & w_cur[7:0]) | w_uio_bad;
    assign w_err_next = (w_bad && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    assign w_n        = (num_vec > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_vec;
    assign w_last     = {1'b0, r_idx} == r_n - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_n           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            dut_ui_in     <= '0;
            dut_uio_in    <= '0;
            dut_ena       <= 1'b0;
            dut_rst_n     <= 1'b0;
`ifdef TT_PIN_UIO_CHECK_EN
            last_fail_uo  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_state       <= S_DRST;
                    r_n           <= w_n;
                    r_cnt         <= '0;
                    r_idx         <= '0;
                    busy          <= 1'b1;
                    done          <= 1'b0;
                    pass          <= 1'b0;
                    err_count     <= '0;
                    first_err_idx <= '0;
                    dut_ena       <= 1'b1;
                    dut_rst_n     <= 1'b0;
                    dut_ui_in     <= '0;
                    dut_uio_in    <= '0;
                end
                S_DRST: if (r_cnt == CW'(RST_CYCLES - 1)) begin
                    r_cnt     <= '0;
                    dut_rst_n <= 1'b1;
                    if (r_n == '0) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                    end else begin
                        r_state    <= S_APPLY;
                        dut_ui_in  <= w_cur[31:24];
                        dut_uio_in <= w_cur[23:16];
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_APPLY: if (r_cnt == CW'(SETTLE)) begin
                    r_cnt     <= '0;
                    err_count <= w_err_next;
                    if (w_bad && err_count == '0) first_err_idx <= r_idx;
`ifdef TT_PIN_UIO_CHECK_EN
                    if (w_bad) last_fail_uo <= dut_uo_out;
`endif
                    if (w_last) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= w_err_next == '0;
                    end else begin
                        r_idx      <= r_idx + 1'b1;
                        dut_ui_in  <= w_nxt_pins[15:8];
                        dut_uio_in <= w_nxt_pins[7:0];
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
